// File: rtl/alu_pkg.sv
// Shared constants for the total_alu MIPS-subset ALU: funct codes, default width and MULTU/DIVU FSM states.
package alu_pkg;

  localparam int WIDTH = 32;

  localparam logic [5:0] FN_AND   = 6'd36;
  localparam logic [5:0] FN_OR    = 6'd37;
  localparam logic [5:0] FN_ADD   = 6'd32;
  localparam logic [5:0] FN_SUB   = 6'd34;
  localparam logic [5:0] FN_SLT   = 6'd42;
  localparam logic [5:0] FN_SRL   = 6'd2;
  localparam logic [5:0] FN_MULTU = 6'd25;
  localparam logic [5:0] FN_MFHI  = 6'd16;
  localparam logic [5:0] FN_MFLO  = 6'd18;
  localparam logic [5:0] FN_DIVU  = 6'd27;

  typedef enum logic {
    IDLE,
    RUN
  } state_t;

endpackage

// File: rtl/alu_multu_seq.sv
// Multi-cycle unit: shift-add MULTU and, with TOTAL_ALU_DIVU_EN defined, restoring DIVU.
// Produces the HI/LO write value and its write-enable on the commit edge.
module alu_multu_seq
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] data_a,
  input  logic [WIDTH-1:0] data_b,
  input  logic [5:0]       funct,
  output logic             wr_en,
  output logic [WIDTH-1:0] wr_hi,
  output logic [WIDTH-1:0] wr_lo
);

  localparam int CNT_W = $clog2(WIDTH);

  state_t                 state_q, state_d;
  logic [5:0]             prev_q;
  logic [CNT_W-1:0]       count_q, count_d;
  logic [WIDTH-1:0]       opnd_q, opnd_d;
  logic [2*WIDTH-1:0]     acc_q, acc_d;
  logic                   div_q, div_d;

  logic                   is_mul, is_div, start, held, sel_div;
  logic [WIDTH-1:0]       src_opnd;
  logic [2*WIDTH-1:0]     src_acc, acc_step;

  // One shift-add iteration: acc holds {partial product, remaining multiplier bits}.
  function automatic logic [2*WIDTH-1:0] mul_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   m);
    logic [WIDTH:0] sum;
    sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, m} : '0);
    return {sum, acc[WIDTH-1:1]};
  endfunction

`ifdef TOTAL_ALU_DIVU_EN
  // One restoring iteration: acc holds {remainder, dividend/quotient bits}.
  // A zero divisor naturally yields quotient all-ones and remainder = dividend.
  function automatic logic [2*WIDTH-1:0] div_step(input logic [2*WIDTH-1:0] acc,
                                                  input logic [WIDTH-1:0]   d);
    logic [WIDTH:0]   rem_sh;
    logic [WIDTH-1:0] quo_sh;
    rem_sh = acc[2*WIDTH-1:WIDTH-1];
    quo_sh = {acc[WIDTH-2:0], 1'b0};
    if (rem_sh >= {1'b0, d}) begin
      rem_sh    = rem_sh - {1'b0, d};
      quo_sh[0] = 1'b1;
    end
    return {rem_sh[WIDTH-1:0], quo_sh};
  endfunction

  assign is_div = (funct == FN_DIVU);
`else
  assign is_div = 1'b0;
`endif

  assign is_mul  = (funct == FN_MULTU);
  assign start   = (state_q == IDLE) && (is_mul || is_div) && (funct != prev_q);
  assign held    = div_q ? is_div : is_mul;
  assign sel_div = (state_q == IDLE) ? is_div : div_q;

  // The start edge already performs iteration 1 on the live operands.
  always_comb begin
    src_opnd = opnd_q;
    src_acc  = acc_q;
    if (state_q == IDLE) begin
      src_opnd = is_div ? data_b : data_a;
      src_acc  = {{WIDTH{1'b0}}, (is_div ? data_a : data_b)};
    end
  end

`ifdef TOTAL_ALU_DIVU_EN
  assign acc_step = sel_div ? div_step(src_acc, src_opnd) : mul_step(src_acc, src_opnd);
`else
  assign acc_step = sel_div ? src_acc : mul_step(src_acc, src_opnd);
`endif

  // NOTE: every signal written here gets a default first, so no latch is inferred.
  always_comb begin
    state_d = state_q;
    count_d = count_q;
    opnd_d  = opnd_q;
    acc_d   = acc_q;
    div_d   = div_q;
    wr_en   = 1'b0;
    wr_hi   = acc_step[2*WIDTH-1:WIDTH];
    wr_lo   = acc_step[WIDTH-1:0];
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = RUN;
          div_d   = is_div;
          opnd_d  = src_opnd;
          acc_d   = acc_step;
          count_d = CNT_W'(1);
        end
      end
      RUN: begin
        if (!held) begin
          state_d = IDLE;
        end else if (count_q == CNT_W'(WIDTH - 1)) begin
          wr_en   = 1'b1;
          state_d = IDLE;
        end else begin
          acc_d   = acc_step;
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // NOTE: clocked state uses non-blocking assignments so all flops update together.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      prev_q  <= '0;
      count_q <= '0;
      opnd_q  <= '0;
      acc_q   <= '0;
      div_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= funct;
      count_q <= count_d;
      opnd_q  <= opnd_d;
      acc_q   <= acc_d;
      div_q   <= div_d;
    end
  end

endmodule

// File: rtl/total_alu.sv
// 32-bit MIPS-subset ALU: combinational ops, HI/LO registers and a multi-cycle MULTU.
// Define TOTAL_ALU_DIVU_EN to add DIVU (funct 27) to the multi-cycle unit.
module total_alu
  import alu_pkg::*;
#(
  parameter int WIDTH = alu_pkg::WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] dataA,
  input  logic [WIDTH-1:0] dataB,
  input  logic [5:0]       Signal,
  output logic [WIDTH-1:0] Output
);

  logic             wr_en;
  logic [WIDTH-1:0] wr_hi, wr_lo;
  logic [WIDTH-1:0] hi_q, lo_q;
  logic             slt;

  alu_multu_seq #(.WIDTH(WIDTH)) u_seq (
    .clk    (clk),
    .rst_n  (reset),
    .data_a (dataA),
    .data_b (dataB),
    .funct  (Signal),
    .wr_en  (wr_en),
    .wr_hi  (wr_hi),
    .wr_lo  (wr_lo)
  );

  // HI/LO change only on a completed multi-cycle operation.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wr_en) begin
      hi_q <= wr_hi;
      lo_q <= wr_lo;
    end
  end

  assign slt = $signed(dataA) < $signed(dataB);

  // MULTU, DIVU and unknown codes fall through to zero.
  always_comb begin
    Output = '0;
    case (Signal)
      FN_AND:  Output = dataA & dataB;
      FN_OR:   Output = dataA | dataB;
      FN_ADD:  Output = dataA + dataB;
      FN_SUB:  Output = dataA - dataB;
      FN_SLT:  Output = {{(WIDTH-1){1'b0}}, slt};
      FN_SRL:  Output = dataA >> dataB[$clog2(WIDTH)-1:0];
      FN_MFHI: Output = hi_q;
      FN_MFLO: Output = lo_q;
      default: Output = '0;
    endcase
  end

endmodule

// File: tb/tb_total_alu.sv
// Self-checking bench for total_alu: directed cases plus randomized ops against a plain-arithmetic model.
module tb_total_alu;

  localparam logic [5:0] C_AND = 6'd36, C_OR = 6'd37, C_ADD = 6'd32, C_SUB = 6'd34;
  localparam logic [5:0] C_SLT = 6'd42, C_SRL = 6'd2, C_MULTU = 6'd25;
  localparam logic [5:0] C_MFHI = 6'd16, C_MFLO = 6'd18, C_DIVU = 6'd27;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] dataA, dataB, Output;
  logic [5:0]  Signal;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  total_alu dut (
    .clk    (clk),
    .reset  (reset),
    .dataA  (dataA),
    .dataB  (dataB),
    .Signal (Signal),
    .Output (Output)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)", tag, got, got, exp, exp);
    end
  endtask

  function automatic logic [31:0] ref_out(input logic [5:0] code, input logic [31:0] a,
                                          input logic [31:0] b);
    longint sa, sb;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (code)
      C_AND:   return a & b;
      C_OR:    return a | b;
      C_ADD:   return 32'((64'(a) + 64'(b)) % 64'h1_0000_0000);
      C_SUB:   return 32'((64'h1_0000_0000 + 64'(a) - 64'(b)) % 64'h1_0000_0000);
      C_SLT:   return (sa < sb) ? 32'd1 : 32'd0;
      C_SRL:   return 32'(64'(a) / (64'd1 << (b % 32)));
      C_MFHI:  return m_hi;
      C_MFLO:  return m_lo;
      default: return 32'd0;
    endcase
  endfunction

  // Apply one single-cycle op, check the combinational output mid-cycle, then take the edge.
  task automatic do_op(input string tag, input logic [5:0] code, input logic [31:0] a,
                       input logic [31:0] b);
    Signal = code;
    dataA  = a;
    dataB  = b;
    @(negedge clk);
    check(tag, Output, ref_out(code, a, b));
    @(posedge clk);
    #1;
  endtask

  // Hold a multi-cycle code for n edges with operands scrambled after the start edge.
  task automatic run_long(input logic [5:0] code, input logic [31:0] a, input logic [31:0] b,
                          input int n);
    logic [63:0] p;
    logic        active;
    Signal = code;
    dataA  = a;
    dataB  = b;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check("busy_out", Output, 32'd0);
      @(posedge clk);
      #1;
      dataA = $urandom;
      dataB = $urandom;
    end
    active = (code == C_MULTU);
`ifdef TOTAL_ALU_DIVU_EN
    active = active || (code == C_DIVU);
`endif
    if (active && n >= 32) begin
      if (code == C_MULTU) begin
        p    = 64'(a) * 64'(b);
        m_hi = p[63:32];
        m_lo = p[31:0];
      end else if (b == 0) begin
        m_lo = 32'hFFFF_FFFF;
        m_hi = a;
      end else begin
        m_lo = a / b;
        m_hi = a % b;
      end
    end
    Signal = C_MFLO;
  endtask

  function automatic logic [31:0] pick_val();
    case ($urandom_range(0, 4))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      default: return $urandom;
    endcase
  endfunction

  logic [5:0] rnd_codes [12];

  initial begin
    rnd_codes = '{C_AND, C_OR, C_ADD, C_SUB, C_SLT, C_SRL, C_MFHI, C_MFLO,
                  6'd0, 6'd63, 6'd1, 6'd50};
    reset  = 1'b0;
    Signal = 6'd0;
    dataA  = '0;
    dataB  = '0;
    #12;
    reset = 1'b1;
    @(posedge clk);
    #1;

    do_op("rst_hi", C_MFHI, 0, 0);
    do_op("rst_lo", C_MFLO, 0, 0);

    do_op("add", C_ADD, 7, 5);
    check("add_val", Output, 32'd12);
    do_op("sub", C_SUB, 5, 7);
    do_op("and", C_AND, 12, 10);
    do_op("or", C_OR, 12, 10);
    do_op("slt_neg", C_SLT, 32'hFFFF_FFFF, 1);
    do_op("slt_pos", C_SLT, 1, 32'hFFFF_FFFF);
    do_op("srl_31", C_SRL, 32'h8000_0000, 31);
    do_op("srl_b5", C_SRL, 32'hF0, 36);

    run_long(C_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32);
    do_op("max_hi", C_MFHI, 0, 0);
    do_op("max_lo", C_MFLO, 0, 0);

    run_long(C_MULTU, 65536, 65536, 32);
    do_op("k_hi", C_MFHI, 0, 0);
    run_long(C_MULTU, 3, 5, 10);
    do_op("abort_add", C_ADD, 3, 5);
    do_op("abort_hi", C_MFHI, 0, 0);
    do_op("abort_lo", C_MFLO, 0, 0);

    Signal = C_MULTU;
    dataA  = 123;
    dataB  = 456;
    repeat (10) @(posedge clk);
    #2;
    reset  = 1'b0;
    m_hi   = '0;
    m_lo   = '0;
    Signal = C_MFHI;
    #1;
    check("midrst_hi", Output, 32'd0);
    Signal = C_MFLO;
    #1;
    check("midrst_lo", Output, 32'd0);
    @(posedge clk);
    #3;
    reset = 1'b1;
    run_long(C_MULTU, 6, 7, 32);
    do_op("six7_lo", C_MFLO, 0, 0);
    do_op("six7_hi", C_MFHI, 0, 0);

`ifdef TOTAL_ALU_DIVU_EN
    run_long(C_DIVU, 100, 7, 32);
    do_op("div_lo", C_MFLO, 0, 0);
    do_op("div_hi", C_MFHI, 0, 0);
    run_long(C_DIVU, 9, 0, 32);
    do_op("div0_lo", C_MFLO, 0, 0);
    do_op("div0_hi", C_MFHI, 0, 0);
`else
    run_long(C_DIVU, 100, 7, 33);
    do_op("undef27_lo", C_MFLO, 0, 0);
    do_op("undef27_hi", C_MFHI, 0, 0);
`endif

    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: begin
          if ($urandom_range(0, 2) == 0)
            run_long(C_MULTU, pick_val(), pick_val(), $urandom_range(1, 31));
          else
            run_long(C_MULTU, pick_val(), pick_val(), 32 + $urandom_range(0, 2));
          do_op("rnd_mlo", C_MFLO, 0, 0);
          do_op("rnd_mhi", C_MFHI, 0, 0);
        end
`ifdef TOTAL_ALU_DIVU_EN
        1: begin
          run_long(C_DIVU, pick_val(), ($urandom_range(0, 3) == 0) ? 32'd0 : pick_val(),
                   32 + $urandom_range(0, 1));
          do_op("rnd_dlo", C_MFLO, 0, 0);
          do_op("rnd_dhi", C_MFHI, 0, 0);
        end
`endif
        default: begin
          do_op("rnd_op", rnd_codes[$urandom_range(0, 11)], pick_val(), pick_val());
        end
      endcase
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
